div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Round-robin controller that shares one sequential start/done divider among N requesters.
- Arbitrates requests and latches the granted requester's operands.
- Drives the divider's start/done handshake and returns quotient/remainder tagged with the requester ID.
- Sits between the requesting units and the divider core inside fpga_top; handles divide-by-zero without invoking the divider.

Parameters:
N_REQ, 4, number of requesters (2..8)
DIVIDEND_WIDTH, 8, dividend/quotient width
DIVISOR_WIDTH, 8, divisor/remainder width
ID_WIDTH, 2, requester index width, ceil(log2(N_REQ))
TIMEOUT_CYCLES, 1024, watchdog limit (used only with DIV_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level; held with operands until own gnt bit seen
dividend_bus  in  N_REQ*DIVIDEND_WIDTH  packed dividends, requester k at slice k
divisor_bus  in  N_REQ*DIVISOR_WIDTH  packed divisors
gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester captured
div_start  out  1  start to divider, level
div_dividend  out  DIVIDEND_WIDTH  latched dividend to divider
div_divisor  out  DIVISOR_WIDTH  latched divisor to divider
div_done  in  1  divider done, level; divider clears it once div_start is low
div_quotient  in  DIVIDEND_WIDTH  divider quotient, valid while div_done=1
div_remainder  in  DIVISOR_WIDTH  divider remainder, valid while div_done=1
res_valid  out  1  one-cycle result pulse
res_id  out  ID_WIDTH  requester index of result
res_quotient  out  DIVIDEND_WIDTH  registered quotient, held until next res_valid
res_remainder  out  DIVISOR_WIDTH  registered remainder, held until next res_valid
res_err  out  1  qualifies res_valid: divide-by-zero (or timeout)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = N_REQ-1 so requester 0 wins first. rst mid-operation aborts at the next edge: div_start drops, no res_valid issued.
- States: IDLE, ISSUE, WAIT, DRAIN, ZERO.
- IDLE:
  - If req != 0: pick the first set bit searching upward from pointer+1 with wrap.
  - Next edge: gnt[k]=1 for one cycle; latch slices k into div_dividend/div_divisor; latch res_id=k; pointer=k.
  - Go to ZERO if the divisor slice is 0, else ISSUE.
  - req=0: stay in IDLE, all pulses 0.
- ISSUE: div_start<=1; go to WAIT.
- WAIT:
  - div_start held 1.
  - On div_done=1: register div_quotient/div_remainder into res_*; res_valid<=1, res_err<=0, div_start<=0; go to DRAIN.
- DRAIN: stay until div_done=0, then IDLE. No new grant until the divider has cleared done.
- ZERO:
  - res_quotient=all ones, res_remainder=latched dividend truncated/zero-extended to DIVISOR_WIDTH, res_err=1, res_valid=1.
  - Go to IDLE. Divider never started.
- Latency, nonzero divisor: gnt at cycle G; div_start high from G+1; res_valid one cycle after the first div_done=1 sample. Divide-by-zero: res_valid at G+1.
- Simultaneous requests: strict round robin; a continuously requesting unit waits at most N_REQ-1 grants.
- A requester may re-assert req the cycle after its gnt; it is arbitrated normally at the next IDLE.
- Operands are not re-sampled after gnt; bus changes during a divide have no effect.
- div_done=1 while in IDLE/ISSUE (stale): ignored; an ISSUE with stale done does not produce a result until WAIT samples it.
- res_valid and gnt never assert in the same cycle.

Optional Feature:
- Macro DIV_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without div_done: div_start<=0, res_valid=1, res_err=1, res_quotient=0, res_remainder=0, go to DRAIN.
  - Counter resets with rst.
- When undefined: no counter logic; WAIT waits indefinitely.

Test Plan:
- Single requester 0, dividend 0xF0, divisor 0x0F; divider model done after 8 cycles -> gnt=0001, div_start high 8+ cycles, res_valid with id=0, q=0x10, r=0x00, err=0.
- Requester 2, 0x45 / 0x08 -> id=2, q=0x08, r=0x05; busy high gnt+1 through DRAIN exit.
- req=1111 held continuously from reset, distinct operands -> grant order 0,1,2,3,0; each result id matches its operands.
- Requester 1, 0x45 / 0x00 -> res_valid one cycle after gnt, q=0xFF, r=0x45, err=1, div_start never asserted.
- rst asserted 3 cycles into WAIT -> next edge div_start=0, busy=0, no res_valid; next request granted to requester 0.
- With DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, divider never raises done -> res_valid at WAIT+16, err=1, q=0, r=0; FSM returns to IDLE.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one start/done divider among N_REQ requesters; divide-by-zero answered locally.
// Optional watchdog on the divider wait is enabled by defining DIV_ARB_TIMEOUT_EN.
module div_share_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req,
  input  logic [N_REQ*DIVIDEND_WIDTH-1:0]     dividend_bus,
  input  logic [N_REQ*DIVISOR_WIDTH-1:0]      divisor_bus,
  output logic [N_REQ-1:0]                    gnt,
  output logic                                div_start,
  output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
  output logic [DIVISOR_WIDTH-1:0]            div_divisor,
  input  logic                                div_done,
  input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]            div_remainder,
  output logic                                res_valid,
  output logic [ID_WIDTH-1:0]                 res_id,
  output logic [DIVIDEND_WIDTH-1:0]           res_quotient,
  output logic [DIVISOR_WIDTH-1:0]            res_remainder,
  output logic                                res_err,
  output logic                                busy,
  output logic [2:0]                          dbg_state
);

  // Handshake: req[k] is a level held with its operands until gnt[k] pulses; the divider
  // sees div_start as a level, answers with div_done level, and drops done after start falls.

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, ZERO} state_t;

  if (N_REQ < 2 || N_REQ > 8 || (1 << ID_WIDTH) < N_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("div_share_arbiter: unsupported parameter combination");
  end

  state_t                     state;
  logic [ID_WIDTH-1:0]        ptr;
  logic [ID_WIDTH-1:0]        pick;
  logic                       found;
  logic [DIVISOR_WIDTH-1:0]   zero_rem;

  // First requester above the pointer, wrapping, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

  assign zero_rem  = DIVISOR_WIDTH'(div_dividend);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= ID_WIDTH'(N_REQ - 1);
      gnt           <= '0;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_err       <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      gnt       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt[pick]    <= 1'b1;
            ptr          <= pick;
            res_id       <= pick;
            div_dividend <= dividend_bus[int'(pick)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
            div_divisor  <= divisor_bus[int'(pick)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
            if (divisor_bus[int'(pick)*DIVISOR_WIDTH +: DIVISOR_WIDTH] == '0)
              state <= ZERO;
            else
              state <= ISSUE;
          end
        end
        ISSUE: begin
          div_start <= 1'b1;
          state     <= WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        WAIT: begin
          if (div_done) begin
            res_quotient  <= div_quotient;
            res_remainder <= div_remainder;
            res_err       <= 1'b0;
            res_valid     <= 1'b1;
            div_start     <= 1'b0;
            state         <= DRAIN;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            res_quotient  <= '0;
            res_remainder <= '0;
            res_err       <= 1'b1;
            res_valid     <= 1'b1;
            div_start     <= 1'b0;
            state         <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        // Hold off the next grant until the divider has released done.
        DRAIN: begin
          if (!div_done) state <= IDLE;
        end
        ZERO: begin
          res_quotient  <= '1;
          res_remainder <= zero_rem;
          res_err       <= 1'b1;
          res_valid     <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: behavioural divider, grant-order and result scoreboards.
module tb_div_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 8;
  localparam int IW = 2;
  localparam int EW = IW + DW + SW + 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] dividend_bus;
  logic [N*SW-1:0] divisor_bus;
  logic [N-1:0]    gnt;
  logic            div_start;
  logic [DW-1:0]   div_dividend;
  logic [SW-1:0]   div_divisor;
  logic            div_done;
  logic [DW-1:0]   div_quotient;
  logic [SW-1:0]   div_remainder;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic [DW-1:0]   res_quotient;
  logic [SW-1:0]   res_remainder;
  logic            res_err;
  logic            busy;
  logic [2:0]      dbg_state;

  div_share_arbiter #(
    .N_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .dividend_bus(dividend_bus), .divisor_bus(divisor_bus),
    .gnt(gnt), .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .res_valid(res_valid), .res_id(res_id), .res_quotient(res_quotient),
    .res_remainder(res_remainder), .res_err(res_err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural divider: done after div_delay cycles of start, cleared once start drops
  int div_delay = 8;
  int dcnt = 0;
  always @(posedge clk) begin
    if (rst || !div_start) begin
      div_done <= 1'b0;
      dcnt     <= 0;
    end else if (!div_done) begin
      if (dcnt >= div_delay - 1) begin
        div_done      <= 1'b1;
        div_quotient  <= (div_divisor == 0) ? '0 : div_dividend / div_divisor;
        div_remainder <= (div_divisor == 0) ? '0 : div_dividend % div_divisor;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            exp_gnt[$];
  int            checks = 0;
  int            failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] expect_res(input int k, input logic [DW-1:0] a, input logic [SW-1:0] b);
    if (b == 0) return {IW'(k), 8'hFF, a, 1'b1};
    return {IW'(k), DW'(a / b), SW'(a % b), 1'b0};
  endfunction

  // monitor
  int   gnt_cyc = -10;
  int   done_cyc = -10;
  bit   done_d = 0;
  bit   start_seen = 0;
  bit   pend_zero = 0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            g;
    if (!rst) begin
      if (gnt != 0) begin
        check_eq("gnt_res_overlap", res_valid, 0);
        if (exp_gnt.size() == 0) check_eq("gnt_unexpected", gnt, 0);
        else begin
          g = exp_gnt.pop_front();
          check_eq("gnt_onehot", gnt, 32'(1) << g);
        end
        gnt_cyc    = cyc;
        start_seen = 0;
        pend_zero  = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
      end
      if (gnt_cyc >= 0 && cyc == gnt_cyc + 1 && !pend_zero) check_eq("start_latency", div_start, 1);
      if (div_start) start_seen = 1;
      if (div_done && !done_d) done_cyc = cyc;
      done_d = div_done;
      if (res_valid) begin
        if (exp_q.size() == 0) check_eq("res_unexpected", res_valid, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("res_id", res_id, e[EW-1 -: IW]);
          check_eq("res_quotient", res_quotient, e[DW+SW -: DW]);
          check_eq("res_remainder", res_remainder, e[SW:1]);
          check_eq("res_err", res_err, e[0]);
          if (e[0]) begin
            check_eq("zero_latency", cyc - gnt_cyc, 1);
            check_eq("zero_no_start", start_seen, 0);
          end else begin
            check_eq("res_latency", cyc - done_cyc, 1);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [SW-1:0] b);
    dividend_bus[k*DW +: DW] = a;
    divisor_bus[k*SW +: SW]  = b;
  endtask

  task automatic run_grants(input logic [N-1:0] mask, input bit hold, input int n);
    int cnt = 0;
    int waited = 0;
    req = mask;
    while (cnt < n && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (gnt != 0) begin
        cnt++;
        if (cnt == n) req = '0;
        else if (!hold) req = req & ~gnt;
      end
    end
    req = '0;
    check_eq("grant_count", cnt, n);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((exp_q.size() != 0 || busy) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("idle_reached", (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic single(input int k, input logic [DW-1:0] a, input logic [SW-1:0] b);
    set_ops(k, a, b);
    exp_gnt.push_back(k);
    exp_q.push_back(expect_res(k, a, b));
    run_grants(N'(1) << k, 0, 1);
    check_eq("busy_after_gnt", busy, 1);
    // operands must not be re-sampled after the grant
    dividend_bus = $urandom;
    divisor_bus  = $urandom;
    wait_idle();
  endtask

  logic [DW-1:0] dvd_tab[N] = '{8'h64, 8'h7B, 8'hC8, 8'h09};
  logic [SW-1:0] dvs_tab[N] = '{8'h07, 8'h05, 8'h0A, 8'h03};
  int order_a[5] = '{0, 1, 2, 3, 0};

  initial begin
    int waited;
    rst = 1'b1;
    req = '0;
    dividend_bus = '0;
    divisor_bus  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_div_start", div_start, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_id", res_id, 0);
    check_eq("rst_res_q", res_quotient, 0);
    check_eq("rst_res_r", res_remainder, 0);
    check_eq("rst_res_err", res_err, 0);
    check_eq("rst_div_dividend", div_dividend, 0);
    check_eq("rst_div_divisor", div_divisor, 0);

    // all four requesting from reset: strict round robin starting at 0
    for (int k = 0; k < N; k++) set_ops(k, dvd_tab[k], dvs_tab[k]);
    for (int i = 0; i < 5; i++) begin
      exp_gnt.push_back(order_a[i]);
      exp_q.push_back(expect_res(order_a[i], dvd_tab[order_a[i]], dvs_tab[order_a[i]]));
    end
    rst = 1'b0;
    run_grants(4'hF, 1, 5);
    wait_idle();

    single(0, 8'hF0, 8'h0F);
    single(2, 8'h45, 8'h08);
    single(1, 8'h45, 8'h00);
    single(3, 8'hFF, 8'h01);
    single(0, 8'h00, 8'h00);

    for (int i = 0; i < 10; i++) begin
      int k;
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      k = $urandom_range(0, N - 1);
      a = DW'($urandom_range(0, 255));
      b = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom_range(1, 255));
      div_delay = $urandom_range(1, 12);
      single(k, a, b);
    end

    // reset during WAIT aborts the divide without a result
    div_delay = 100;
    set_ops(2, 8'h45, 8'h08);
    exp_gnt.push_back(2);
    exp_q.push_back(expect_res(2, 8'h45, 8'h08));
    run_grants(4'b0100, 0, 1);
    waited = 0;
    while (!div_start && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("start_before_abort", div_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_gnt.delete();
    @(negedge clk);
    check_eq("abort_div_start", div_start, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_res_valid", res_valid, 0);
    rst = 1'b0;
    div_delay = 8;

    // pointer is back at N_REQ-1: requester 0 wins over 3
    set_ops(0, 8'h90, 8'h0C);
    set_ops(3, 8'h33, 8'h00);
    exp_gnt.push_back(0);
    exp_q.push_back(expect_res(0, 8'h90, 8'h0C));
    exp_gnt.push_back(3);
    exp_q.push_back(expect_res(3, 8'h33, 8'h00));
    run_grants(4'b1001, 0, 2);
    wait_idle();

    repeat (5) @(negedge clk);
    check_eq("res_leftover", exp_q.size(), 0);
    check_eq("gnt_leftover", exp_gnt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
